// File: rtl/inverse_sigmoid_search_if.sv
// Request/response bundle for the inverse-sigmoid search block.
// The block side uses the slave modport; the requester uses master.
`timescale 1ns/1ps
interface inverse_sigmoid_search_if #(
   parameter int DATA_IWIDTH = 16,
   parameter int DATA_OWIDTH = 6
);
   logic                   ivalid;
   logic                   iready;
   logic [DATA_IWIDTH-1:0] idata;
   logic                   ovalid;
   logic                   oready;
   logic [DATA_OWIDTH-1:0] odata;
   logic                   oclamp;

   modport slave  (input  ivalid, idata, oready,
                   output iready, ovalid, odata, oclamp);
   modport master (output ivalid, idata, oready,
                   input  iready, ovalid, odata, oclamp);
endinterface

// File: rtl/inverse_sigmoid_search.sv
// Inverse sigmoid by 6-step binary search over a 64-entry sigmoid table.
// One request in flight: IDLE accepts, SEARCH resolves one index bit per cycle, DONE holds the result.
`timescale 1ns/1ps
module inverse_sigmoid_search #(
   parameter int DATA_IWIDTH = 16,
   parameter int DATA_OWIDTH = 6
) (
   input  logic                    clk,
   input  logic                    rst_n,
   inverse_sigmoid_search_if.slave bus
);
   localparam logic [31:0] P_MIN = 32'h0000_024D;
   localparam logic [31:0] P_MAX = 32'h0000_7FFF;

   typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

   // floor(sigmoid(k/8) * 32768) for k = 0..32
   function automatic logic [15:0] t_upper(input logic [5:0] k);
      logic [15:0] t;
      case (k)
         6'd0:  t = 16'h4000;  6'd1:  t = 16'h43FE;  6'd2:  t = 16'h47F5;  6'd3:  t = 16'h4BDC;
         6'd4:  t = 16'h4FAC;  6'd5:  t = 16'h535F;  6'd6:  t = 16'h56EF;  6'd7:  t = 16'h5A57;
         6'd8:  t = 16'h5D93;  6'd9:  t = 16'h60A1;  6'd10: t = 16'h637E;  6'd11: t = 16'h662A;
         6'd12: t = 16'h68A6;  6'd13: t = 16'h6AF1;  6'd14: t = 16'h6D0C;  6'd15: t = 16'h6EFB;
         6'd16: t = 16'h70BD;  6'd17: t = 16'h7257;  6'd18: t = 16'h73CB;  6'd19: t = 16'h751B;
         6'd20: t = 16'h764A;  6'd21: t = 16'h775A;  6'd22: t = 16'h784F;  6'd23: t = 16'h792A;
         6'd24: t = 16'h79ED;  6'd25: t = 16'h7A9C;  6'd26: t = 16'h7B38;  6'd27: t = 16'h7BC3;
         6'd28: t = 16'h7C3F;  6'd29: t = 16'h7CAD;  6'd30: t = 16'h7D0F;  6'd31: t = 16'h7D65;
         default: t = 16'h7DB2;
      endcase
      return t;
   endfunction

   // sigmoid(-x) = 1 - sigmoid(x); the scaled value is never an integer, so the floor mirrors to 0x7FFF - T
   function automatic logic [15:0] t_lookup(input logic [5:0] i);
      if (i[5]) begin
         return t_upper({1'b0, i[4:0]});
      end
      return 16'h7FFF - t_upper(6'd32 - {1'b0, i[4:0]});
   endfunction

   state_t                 r_state, w_state_next;
   logic [DATA_IWIDTH-1:0] r_p, w_p_next;
   logic [5:0]             r_lo, w_lo_next;
   logic [2:0]             r_b, w_b_next;
   logic [DATA_OWIDTH-1:0] r_odata, w_odata_next;
   logic                   r_oclamp, w_oclamp_next;
   logic                   w_iready, w_ovalid;
   logic [5:0]             w_cand, w_lo_fin, w_code;
   logic [15:0]            w_t_cand;
   logic                   w_t_le, w_clamp;

   assign w_cand   = r_lo | (6'd1 << r_b);
   assign w_t_cand = t_lookup(w_cand);
   assign w_t_le   = (32'(w_t_cand) <= 32'(r_p));
   assign w_lo_fin = w_t_le ? w_cand : r_lo;
   assign w_code   = {~w_lo_fin[5], w_lo_fin[4:0]};
   assign w_clamp  = (32'(r_p) < P_MIN) || (32'(r_p) > P_MAX);

   always_comb begin
      w_state_next  = r_state;
      w_p_next      = r_p;
      w_lo_next     = r_lo;
      w_b_next      = r_b;
      w_odata_next  = r_odata;
      w_oclamp_next = r_oclamp;
      w_iready      = 1'b0;
      w_ovalid      = 1'b0;
      case (r_state)
         IDLE: begin
            w_iready = rst_n;
            if (bus.ivalid) begin
               w_p_next     = bus.idata;
               w_lo_next    = 6'd0;
               w_b_next     = 3'd5;
               w_state_next = SEARCH;
            end
         end
         SEARCH: begin
            w_lo_next = w_lo_fin;
            if (r_b == 3'd0) begin
               w_b_next      = 3'd5;
               w_odata_next  = DATA_OWIDTH'($signed(w_code));
               w_oclamp_next = w_clamp;
               w_state_next  = DONE;
            end else begin
               w_b_next = r_b - 3'd1;
            end
         end
         DONE: begin
            w_ovalid = 1'b1;
            if (bus.oready) begin
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_p      <= '0;
         r_lo     <= 6'd0;
         r_b      <= 3'd5;
         r_odata  <= '0;
         r_oclamp <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_p      <= w_p_next;
         r_lo     <= w_lo_next;
         r_b      <= w_b_next;
         r_odata  <= w_odata_next;
         r_oclamp <= w_oclamp_next;
      end
   end

   assign bus.iready = w_iready;
   assign bus.ovalid = w_ovalid;
   assign bus.odata  = r_odata;
   assign bus.oclamp = r_oclamp;
endmodule

// File: tb/tb_inverse_sigmoid_search.sv
// Scoreboard bench for inverse_sigmoid_search: expectations come from a real-arithmetic sigmoid table.
// A driver issues requests and queues expected results; a monitor checks every presented result.
`timescale 1ns/1ps
module tb_inverse_sigmoid_search;
   typedef struct {
      logic [15:0] p;
      logic [5:0]  odata;
      logic        oclamp;
      int          acc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   fails = 0;
   int   cyc = 0;
   int   tmodel[64];
   exp_t sb_q[$];
   bit   bp_mode = 1'b0;
   logic oready_fix = 1'b1;
   logic prev_ovalid = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   inverse_sigmoid_search_if #(.DATA_IWIDTH(16), .DATA_OWIDTH(6)) bus ();

   inverse_sigmoid_search #(.DATA_IWIDTH(16), .DATA_OWIDTH(6)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endfunction

   function automatic exp_t model(input logic [15:0] p);
      exp_t e;
      int   r = 0;
      for (int i = 0; i < 64; i++) begin
         if (tmodel[i] <= int'(p)) r = i;
      end
      e.p      = p;
      e.odata  = 6'(r - 32);
      e.oclamp = (int'(p) < tmodel[0]) || (int'(p) > 32767);
      e.acc    = 0;
      return e;
   endfunction

   task automatic send(input logic [15:0] p, input bit fixed, input logic [5:0] eo, input logic ec);
      exp_t e;
      int   n = 0;
      e = model(p);
      if (fixed) begin
         e.odata  = eo;
         e.oclamp = ec;
      end
      @(posedge clk); #1;
      bus.ivalid = 1'b1;
      bus.idata  = p;
      @(negedge clk);
      while (!bus.iready && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!bus.iready) begin
         fails++;
         $display("FAIL accept_timeout: p=0x%04h not accepted within 200 cycles", p);
      end else begin
         e.acc = cyc + 1;
         sb_q.push_back(e);
      end
      @(posedge clk); #1;
      bus.ivalid = 1'b0;
      bus.idata  = 16'($urandom);
   endtask

   task automatic drain();
      int n = 0;
      while (sb_q.size() != 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("drain_pending", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
   endtask

   // oready has a single writer: random in backpressure mode, otherwise the fixed level
   initial begin
      bus.oready = 1'b1;
      forever begin
         @(posedge clk); #2;
         bus.oready = bp_mode ? ($urandom_range(0, 3) != 0) : oready_fix;
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1) begin
            if (bus.ovalid) begin
               if (sb_q.size() == 0) begin
                  checks++;
                  fails++;
                  $display("FAIL unexpected_ovalid: odata=0x%02h oclamp=%0d with no request outstanding",
                           bus.odata, bus.oclamp);
               end else begin
                  chk("odata", 32'(bus.odata), 32'(sb_q[0].odata));
                  chk("oclamp", 32'(bus.oclamp), 32'(sb_q[0].oclamp));
                  chk("iready_while_ovalid", 32'(bus.iready), 32'd0);
                  // counting the accepting edge as the first, ovalid is high after the 7th edge
                  if (!prev_ovalid) chk("latency_edges", 32'(cyc - sb_q[0].acc + 1), 32'd7);
                  if (bus.oready) begin
                     $display("txn p=0x%04h odata=0x%02h oclamp=%0d", sb_q[0].p, bus.odata, bus.oclamp);
                     void'(sb_q.pop_front());
                  end
               end
            end
            prev_ovalid = bus.ovalid;
         end else begin
            prev_ovalid = 1'b0;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   logic [15:0] dp[9] = '{16'h4000, 16'h3FFF, 16'h4001, 16'h024D, 16'h024C,
                          16'h0000, 16'h7D65, 16'hFFFF, 16'h7FFF};
   logic [5:0]  de[9] = '{6'h00, 6'h3F, 6'h00, 6'h20, 6'h20, 6'h20, 6'h1F, 6'h1F, 6'h1F};
   logic        dc[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

   initial begin
      int n;
      logic [15:0] p;
      rst_n      = 1'b0;
      bus.ivalid = 1'b0;
      bus.idata  = 16'h0000;
      for (int i = 0; i < 64; i++) begin
         tmodel[i] = int'($floor(32768.0 / (1.0 + $exp(-(real'(i) - 32.0) / 8.0))));
      end

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_iready", 32'(bus.iready), 32'd0);
      chk("reset_ovalid", 32'(bus.ovalid), 32'd0);
      chk("reset_odata", 32'(bus.odata), 32'd0);
      chk("reset_oclamp", 32'(bus.oclamp), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("iready_after_reset", 32'(bus.iready), 32'd1);

      for (int k = 0; k < 9; k++) send(dp[k], 1'b1, de[k], dc[k]);
      drain();

      for (int i = 0; i < 64; i++) begin
         send(16'(tmodel[i]), 1'b0, 6'h0, 1'b0);
         if (i > 0) send(16'(tmodel[i] - 1), 1'b0, 6'h0, 1'b0);
      end
      drain();

      bp_mode = 1'b1;
      for (int k = 0; k < 150; k++) begin
         p = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(32'h0200, 32'h7FFF));
         send(p, 1'b0, 6'h0, 1'b0);
      end
      drain();
      bp_mode = 1'b0;
      oready_fix = 1'b0;

      // long backpressure in DONE while the input side keeps changing
      send(16'h5000, 1'b0, 6'h0, 1'b0);
      n = 0;
      while (!bus.ovalid && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("bp_ovalid_seen", 32'(bus.ovalid), 32'd1);
      repeat (20) begin
         @(posedge clk); #1;
         bus.ivalid = ~bus.ivalid;
         bus.idata  = 16'($urandom);
      end
      @(posedge clk); #1;
      bus.ivalid = 1'b0;
      oready_fix = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("bp_release_ovalid", 32'(bus.ovalid), 32'd0);
      chk("bp_release_iready", 32'(bus.iready), 32'd1);
      chk("bp_release_pending", 32'(sb_q.size()), 32'd0);

      // reset during the 3rd SEARCH cycle abandons the request
      send(16'h1234, 1'b0, 6'h0, 1'b0);
      @(posedge clk);
      @(posedge clk); #1;
      rst_n = 1'b0;
      sb_q.delete();
      @(negedge clk);
      chk("iready_during_reset", 32'(bus.iready), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("abandon_iready", 32'(bus.iready), 32'd1);
      chk("abandon_ovalid", 32'(bus.ovalid), 32'd0);
      repeat (10) @(negedge clk);
      send(16'h70BD, 1'b1, 6'h10, 1'b0);
      drain();

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end
endmodule
